// File: rtl/risky_pipe_ctrl.sv
// Pipeline sequencer for the risky core: arbitrates the shared memory port between
// fetch and execute loads/stores and drives stall/bubble/flush for control transfers.
module risky_pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dec_valid,
  input  logic [6:0] dec_op,
  input  logic       ex_mem_req,
  input  logic       mem_ack,
  input  logic       br_resolve,
  input  logic       br_taken,
  output logic       fetch_en,
  output logic       dec_stall,
  output logic       ex_bubble,
  output logic       ex_stall,
  output logic       mem_sel,
  output logic       pc_redirect,
  output logic       flush,
  output logic       mem_err,
  output logic [1:0] ctrl_state
);

  localparam int unsigned ST_W  = 2;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned OP_W  = 7;

  localparam logic [ST_W-1:0] ST_RUN  = 2'd0;
  localparam logic [ST_W-1:0] ST_CTRL = 2'd1;
  localparam logic [ST_W-1:0] ST_MEM  = 2'd2;

  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;

  // Last MEM wait count before a forced release.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ctl;

  // State and wait counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and Mealy output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fetch_en    = 1'b1;
    dec_stall   = 1'b0;
    ex_bubble   = 1'b0;
    ex_stall    = 1'b0;
    mem_sel     = 1'b0;
    pc_redirect = 1'b0;
    flush       = 1'b0;
    mem_err     = 1'b0;
    ctrl_state  = state_q;
    ctl         = dec_valid &&
                  (dec_op == OP_BRANCH || dec_op == OP_JAL || dec_op == OP_JALR);

    case (state_q)
      ST_RUN: begin
        if (ex_mem_req) begin
          mem_sel   = 1'b1;
          fetch_en  = 1'b0;
          dec_stall = 1'b1;
          ex_stall  = 1'b1;
          state_d   = ST_MEM;
          cnt_d     = '0;
        end else if (ctl) begin
          fetch_en = 1'b0;
          state_d  = ST_CTRL;
        end
      end
      ST_CTRL: begin
        // ex_mem_req here is a protocol violation and is deliberately ignored.
        if (!br_resolve) begin
          fetch_en  = 1'b0;
          dec_stall = 1'b1;
          ex_bubble = 1'b1;
        end else begin
          if (br_taken) begin
            pc_redirect = 1'b1;
            flush       = 1'b1;
            fetch_en    = 1'b0;
            ex_bubble   = 1'b1;
          end
          state_d = ST_RUN;
        end
      end
      ST_MEM: begin
        mem_sel   = 1'b1;
        fetch_en  = 1'b0;
        dec_stall = 1'b1;
        if (mem_ack || cnt_q == CNT_LAST) begin
          ex_bubble = 1'b1;
          mem_err   = !mem_ack;
          state_d   = ST_RUN;
          cnt_d     = '0;
        end else begin
          ex_stall = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase

    if (!rst_n) begin
      fetch_en    = 1'b0;
      dec_stall   = 1'b0;
      ex_bubble   = 1'b0;
      ex_stall    = 1'b0;
      mem_sel     = 1'b0;
      pc_redirect = 1'b0;
      flush       = 1'b0;
      mem_err     = 1'b0;
      ctrl_state  = ST_RUN;
    end
  end

endmodule

// File: tb/tb_risky_pipe_ctrl.sv
// Bench for risky_pipe_ctrl: directed vector table, hand timeout sequences and
// randomized traffic against a transaction-level reference model.
module tb_risky_pipe_ctrl;

  localparam int unsigned MEM_TIMEOUT = 16;
  localparam logic [6:0]  OP_BR   = 7'b1100011;
  localparam logic [6:0]  OP_JAL  = 7'b1101111;
  localparam logic [6:0]  OP_JALR = 7'b1100111;
  localparam logic [6:0]  OP_NOP  = 7'b0010011;

  typedef struct packed {
    logic       rst_n;
    logic       dec_valid;
    logic [6:0] dec_op;
    logic       ex_mem_req;
    logic       mem_ack;
    logic       br_resolve;
    logic       br_taken;
  } in_t;

  typedef struct packed {
    logic       fetch_en;
    logic       dec_stall;
    logic       ex_bubble;
    logic       ex_stall;
    logic       mem_sel;
    logic       pc_redirect;
    logic       flush;
    logic       mem_err;
    logic [1:0] ctrl_state;
  } outs_t;

  typedef struct {
    in_t   in;
    outs_t exp;
  } vec_t;

  logic clk;
  in_t  drv;
  outs_t dut_o;

  logic fetch_en, dec_stall, ex_bubble, ex_stall, mem_sel, pc_redirect, flush, mem_err;
  logic [1:0] ctrl_state;

  int checks;
  int failures;

  risky_pipe_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (drv.rst_n),
    .dec_valid  (drv.dec_valid),
    .dec_op     (drv.dec_op),
    .ex_mem_req (drv.ex_mem_req),
    .mem_ack    (drv.mem_ack),
    .br_resolve (drv.br_resolve),
    .br_taken   (drv.br_taken),
    .fetch_en   (fetch_en),
    .dec_stall  (dec_stall),
    .ex_bubble  (ex_bubble),
    .ex_stall   (ex_stall),
    .mem_sel    (mem_sel),
    .pc_redirect(pc_redirect),
    .flush      (flush),
    .mem_err    (mem_err),
    .ctrl_state (ctrl_state)
  );

  assign dut_o = '{fetch_en, dec_stall, ex_bubble, ex_stall, mem_sel,
                   pc_redirect, flush, mem_err, ctrl_state};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: is a load/store in progress (and how many MEM cycles elapsed),
  // or is a control transfer waiting to resolve.
  bit          m_in_mem;
  bit          m_br_wait;
  int unsigned m_mem_cycles;

  function automatic bit is_ctl(in_t i);
    return i.dec_valid && (i.dec_op inside {OP_BR, OP_JAL, OP_JALR});
  endfunction

  function automatic outs_t model_out(in_t i);
    outs_t o;
    o = '0;
    if (!i.rst_n) return o;
    o.fetch_en = 1'b1;
    if (m_br_wait) begin
      o.ctrl_state = 2'd1;
      if (!i.br_resolve) begin
        o.fetch_en = 1'b0; o.dec_stall = 1'b1; o.ex_bubble = 1'b1;
      end else if (i.br_taken) begin
        o.fetch_en = 1'b0; o.pc_redirect = 1'b1; o.flush = 1'b1; o.ex_bubble = 1'b1;
      end
    end else if (m_in_mem) begin
      o.ctrl_state = 2'd2;
      o.fetch_en = 1'b0; o.mem_sel = 1'b1; o.dec_stall = 1'b1;
      if (i.mem_ack || (m_mem_cycles + 1 == MEM_TIMEOUT)) begin
        o.ex_bubble = 1'b1;
        o.mem_err   = !i.mem_ack;
      end else begin
        o.ex_stall = 1'b1;
      end
    end else if (i.ex_mem_req) begin
      o.fetch_en = 1'b0; o.mem_sel = 1'b1; o.dec_stall = 1'b1; o.ex_stall = 1'b1;
    end else if (is_ctl(i)) begin
      o.fetch_en = 1'b0;
    end
    return o;
  endfunction

  function automatic void model_step(in_t i);
    if (!i.rst_n) begin
      m_in_mem = 0; m_br_wait = 0; m_mem_cycles = 0;
    end else if (m_br_wait) begin
      if (i.br_resolve) m_br_wait = 0;
    end else if (m_in_mem) begin
      if (i.mem_ack || (m_mem_cycles + 1 == MEM_TIMEOUT)) begin
        m_in_mem = 0; m_mem_cycles = 0;
      end else begin
        m_mem_cycles++;
      end
    end else if (i.ex_mem_req) begin
      m_in_mem = 1; m_mem_cycles = 0;
    end else if (is_ctl(i)) begin
      m_br_wait = 1;
    end
  endfunction

  // Drive one cycle; compare against a given constant or against the model.
  task automatic cycle(input in_t i, input bit use_given, input outs_t given,
                       input string name, input int id);
    outs_t exp;
    @(negedge clk);
    drv = i;
    #2;
    exp = use_given ? given : model_out(i);
    checks++;
    if (dut_o !== exp) begin
      failures++;
      $display("FAIL %s #%0d: got %b expected %b (fe,ds,eb,es,ms,pr,fl,me,st)",
               name, id, dut_o, exp);
    end
    model_step(i);
  endtask

  function automatic in_t mk_in(logic rst, logic dv, logic [6:0] op, logic req,
                                logic ack, logic res, logic tk);
    in_t i;
    i = '{rst, dv, op, req, ack, res, tk};
    return i;
  endfunction

  function automatic outs_t mk_out(logic fe, logic ds, logic eb, logic es, logic ms,
                                   logic pr, logic fl, logic me, logic [1:0] st);
    outs_t o;
    o = '{fe, ds, eb, es, ms, pr, fl, me, st};
    return o;
  endfunction

  vec_t tbl[$];

  task automatic add(input in_t i, input outs_t o);
    vec_t v;
    v.in  = i;
    v.exp = o;
    tbl.push_back(v);
  endtask

  initial begin
    outs_t o_zero, o_run, o_memreq, o_memwait, o_rel, o_brissue, o_ctrlwait, o_taken;
    outs_t o_ntk;
    in_t   i_idle;
    int    ack_pct;
    checks   = 0;
    failures = 0;
    m_in_mem = 0; m_br_wait = 0; m_mem_cycles = 0;
    drv = mk_in(1'b0, 1'b0, OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);

    o_zero     = mk_out(0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
    o_run      = mk_out(1, 0, 0, 0, 0, 0, 0, 0, 2'd0);
    o_memreq   = mk_out(0, 1, 0, 1, 1, 0, 0, 0, 2'd0);
    o_memwait  = mk_out(0, 1, 0, 1, 1, 0, 0, 0, 2'd2);
    o_rel      = mk_out(0, 1, 1, 0, 1, 0, 0, 0, 2'd2);
    o_brissue  = mk_out(0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
    o_ctrlwait = mk_out(0, 1, 1, 0, 0, 0, 0, 0, 2'd1);
    o_taken    = mk_out(0, 0, 1, 0, 0, 1, 1, 0, 2'd1);
    o_ntk      = mk_out(1, 0, 0, 0, 0, 0, 0, 0, 2'd1);
    i_idle     = mk_in(1, 0, OP_NOP, 0, 0, 0, 0);

    // Reset held 3 cycles with activity on the inputs.
    for (int k = 0; k < 3; k++) add(mk_in(0, 1, OP_BR, 1, 0, 0, 0), o_zero);
    add(i_idle, o_run);
    add(mk_in(1, 1, OP_NOP, 0, 1, 1, 1), o_run);           // stray ack/resolve ignored
    add(mk_in(1, 0, OP_BR, 0, 0, 0, 0), o_run);            // invalid branch opcode ignored
    // Load, ack three cycles after the request.
    add(mk_in(1, 1, OP_NOP, 1, 0, 0, 0), o_memreq);
    add(i_idle, o_memwait);
    add(i_idle, o_memwait);
    add(mk_in(1, 0, OP_NOP, 0, 1, 0, 0), o_rel);
    add(i_idle, o_run);
    // BRANCH taken, resolved two cycles after issue.
    add(mk_in(1, 1, OP_BR, 0, 0, 0, 0), o_brissue);
    add(mk_in(1, 1, OP_NOP, 0, 0, 0, 1), o_ctrlwait);
    add(mk_in(1, 1, OP_NOP, 0, 0, 1, 1), o_taken);
    add(mk_in(1, 1, OP_NOP, 0, 0, 1, 1), o_run);
    // JAL not taken on first CTRL cycle.
    add(mk_in(1, 1, OP_JAL, 0, 0, 0, 0), o_brissue);
    add(mk_in(1, 1, OP_NOP, 0, 0, 1, 0), o_ntk);
    add(i_idle, o_run);
    // JALR with an illegal ex_mem_req while in CTRL.
    add(mk_in(1, 1, OP_JALR, 0, 0, 0, 0), o_brissue);
    add(mk_in(1, 1, OP_NOP, 1, 0, 0, 0), o_ctrlwait);
    add(mk_in(1, 1, OP_NOP, 1, 0, 1, 0), o_ntk);
    add(i_idle, o_run);
    // Memory request wins over a branch in decode; branch issues after release.
    add(mk_in(1, 1, OP_BR, 1, 0, 0, 0), o_memreq);
    add(mk_in(1, 1, OP_BR, 0, 1, 0, 0), o_rel);
    add(mk_in(1, 1, OP_BR, 0, 0, 0, 0), o_brissue);
    add(mk_in(1, 0, OP_NOP, 0, 0, 1, 1), o_taken);
    add(i_idle, o_run);
    // Reset aborts MEM and CTRL without emitting pulses.
    add(mk_in(1, 1, OP_NOP, 1, 0, 0, 0), o_memreq);
    add(mk_in(0, 0, OP_NOP, 0, 0, 0, 0), o_zero);
    add(mk_in(1, 0, OP_NOP, 0, 1, 0, 0), o_run);
    add(mk_in(1, 1, OP_JAL, 0, 0, 0, 0), o_brissue);
    add(mk_in(0, 0, OP_NOP, 0, 0, 1, 1), o_zero);
    add(mk_in(1, 0, OP_NOP, 0, 0, 1, 1), o_run);

    foreach (tbl[n]) cycle(tbl[n].in, 1'b1, tbl[n].exp, "vector", n);

    // Timeout: mem_err on the MEM_TIMEOUT-th MEM cycle, then RUN.
    cycle(mk_in(1, 0, OP_NOP, 1, 0, 0, 0), 1'b1, o_memreq, "timeout_req", 0);
    for (int k = 1; k <= 16; k++)
      cycle(i_idle, 1'b1, (k < 16) ? o_memwait : mk_out(0, 1, 1, 0, 1, 0, 0, 1, 2'd2),
            "timeout_mem", k);
    cycle(i_idle, 1'b1, o_run, "timeout_after", 0);
    // Ack arriving exactly on the last allowed cycle is not an error.
    cycle(mk_in(1, 0, OP_NOP, 1, 0, 0, 0), 1'b1, o_memreq, "lastack_req", 0);
    for (int k = 1; k <= 16; k++)
      cycle(mk_in(1, 0, OP_NOP, 0, (k == 16), 0, 0), 1'b1,
            (k < 16) ? o_memwait : o_rel, "lastack_mem", k);
    cycle(i_idle, 1'b1, o_run, "lastack_after", 0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 4000; n++) begin
      in_t ri;
      ack_pct   = ((n / 500) % 2 == 1) ? 2 : 30;
      ri.rst_n      = ($urandom_range(0, 63) != 0);
      ri.dec_valid  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0: ri.dec_op = OP_BR;
        1: ri.dec_op = OP_JAL;
        2: ri.dec_op = OP_JALR;
        default: ri.dec_op = 7'($urandom);
      endcase
      ri.ex_mem_req = ($urandom_range(0, 4) == 0);
      ri.mem_ack    = ($urandom_range(0, 99) < ack_pct);
      ri.br_resolve = ($urandom_range(0, 2) == 0);
      ri.br_taken   = 1'($urandom);
      cycle(ri, 1'b0, '0, "random", n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
